// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: one single-beat req/ack bus transaction per accepted access,
// with store lane steering, load extraction/extension and fault reporting.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        En,
  input  logic        IsLoad,
  input  logic        IsStore,
  input  logic [2:0]  Func3,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  input  logic [4:0]  RdIn,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] LoadData,
  output logic        WriteReg,
  output logic [4:0]  RdOut,
  output logic        Fault,
  output logic [2:0]  FaultCause,
  output logic [31:0] FaultAddr,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemBe,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic [1:0]  DbgState
);

  // Bus handshake: MemReq rises with all bus fields registered and stays high, with the
  // fields frozen, until MemAck is sampled high (or the timeout fires). MemAck is honoured
  // only in S_REQ; anything seen in other states is dropped.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [1:0]  r_lane;
  logic [2:0]  r_f3;
  logic        r_is_load;

  logic        w_legal;
  logic        w_misal;
  logic [2:0]  w_cause;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;

  assign DbgState = r_state;

  always_comb begin
    w_legal = 1'b0;
    if (IsLoad && !IsStore)
      w_legal = (Func3 == 3'b000) || (Func3 == 3'b001) || (Func3 == 3'b010) ||
                (Func3 == 3'b100) || (Func3 == 3'b101);
    else if (IsStore && !IsLoad)
      w_legal = (Func3 == 3'b000) || (Func3 == 3'b001) || (Func3 == 3'b010);

    case (Func3[1:0])
      2'b01:   w_misal = Addr[0];
      2'b10:   w_misal = |Addr[1:0];
      default: w_misal = 1'b0;
    endcase

    // Illegal encodings (including both types set) take priority over alignment
    if (!w_legal)     w_cause = 3'b100;
    else if (w_misal) w_cause = IsLoad ? 3'b001 : 3'b010;
    else              w_cause = 3'b000;

    w_be    = 4'b1111;
    w_wdata = StoreData;
    if (IsStore) begin
      case (Func3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << Addr[1:0];
          w_wdata = {4{StoreData[7:0]}};
        end
        2'b01: begin
          w_be    = Addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{StoreData[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = StoreData;
        end
      endcase
    end
  end

  always_comb begin
    w_byte = MemRData[{r_lane, 3'b000} +: 8];
    w_half = MemRData[{r_lane[1], 4'b0000} +: 16];
    case (r_f3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_ext = {24'd0, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_ext = {16'd0, w_half};
      default: w_load_ext = MemRData;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 16'd0;
      r_lane     <= 2'd0;
      r_f3       <= 3'd0;
      r_is_load  <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      LoadData   <= 32'd0;
      WriteReg   <= 1'b0;
      RdOut      <= 5'd0;
      Fault      <= 1'b0;
      FaultCause <= 3'd0;
      FaultAddr  <= 32'd0;
      MemReq     <= 1'b0;
      MemWe      <= 1'b0;
      MemAddr    <= 32'd0;
      MemWData   <= 32'd0;
      MemBe      <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (En && (IsLoad || IsStore)) begin
            r_lane    <= Addr[1:0];
            r_f3      <= Func3;
            r_is_load <= IsLoad && !IsStore;
            RdOut     <= RdIn;
            FaultAddr <= Addr;
            r_cnt     <= 16'd0;
            Busy      <= 1'b1;
            if (w_cause != 3'b000) begin
              r_state    <= S_RESP;
              Done       <= 1'b1;
              Fault      <= 1'b1;
              FaultCause <= w_cause;
              WriteReg   <= 1'b0;
              LoadData   <= 32'd0;
            end else begin
              r_state  <= S_REQ;
              MemReq   <= 1'b1;
              MemWe    <= IsStore;
              MemAddr  <= {Addr[31:2], 2'b00};
              MemWData <= w_wdata;
              MemBe    <= w_be;
            end
          end
        end
        S_REQ: begin
          // An ack on the limit cycle wins over the timeout
          if (MemAck) begin
            r_state    <= S_RESP;
            MemReq     <= 1'b0;
            Done       <= 1'b1;
            Fault      <= 1'b0;
            FaultCause <= 3'b000;
            WriteReg   <= r_is_load;
            LoadData   <= r_is_load ? w_load_ext : 32'd0;
          end else if (r_cnt == TMAX) begin
            r_state    <= S_RESP;
            MemReq     <= 1'b0;
            Done       <= 1'b1;
            Fault      <= 1'b1;
            FaultCause <= 3'b011;
            WriteReg   <= 1'b0;
            LoadData   <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RESP: begin
          r_state    <= S_IDLE;
          Busy       <= 1'b0;
          Done       <= 1'b0;
          WriteReg   <= 1'b0;
          Fault      <= 1'b0;
          FaultCause <= 3'b000;
          LoadData   <= 32'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed test-plan cases plus randomized accesses
// checked against a spec-level model of steering, extraction and fault rules.
module tb_lsu_mem_stage;

  localparam int T = 4;

  logic        Clk, Reset_n, En, IsLoad, IsStore;
  logic [2:0]  Func3;
  logic [31:0] Addr, StoreData;
  logic [4:0]  RdIn;
  logic        Busy, Done, WriteReg, Fault;
  logic [31:0] LoadData, FaultAddr;
  logic [4:0]  RdOut;
  logic [2:0]  FaultCause;
  logic        MemReq, MemWe, MemAck;
  logic [31:0] MemAddr, MemWData, MemRData;
  logic [3:0]  MemBe;
  logic [1:0]  DbgState;

  int checks = 0;
  int errors = 0;

  lsu_mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .En(En), .IsLoad(IsLoad), .IsStore(IsStore),
    .Func3(Func3), .Addr(Addr), .StoreData(StoreData), .RdIn(RdIn),
    .Busy(Busy), .Done(Done), .LoadData(LoadData), .WriteReg(WriteReg), .RdOut(RdOut),
    .Fault(Fault), .FaultCause(FaultCause), .FaultAddr(FaultAddr),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData), .MemBe(MemBe),
    .MemRData(MemRData), .MemAck(MemAck), .DbgState(DbgState)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // observations gathered by the driver for one access
  int          obs_req_cycles, obs_done_lat;
  logic        obs_stable, obs_we, obs_wr, obs_fault, obs_busy_done, obs_req_at_done;
  logic        obs_done_after, obs_busy_after;
  logic [31:0] obs_addr, obs_wdata, obs_load, obs_faddr;
  logic [3:0]  obs_be;
  logic [4:0]  obs_rd;
  logic [2:0]  obs_cause;

  // reference model
  function automatic logic [2:0] m_cause(input logic ld, st, input logic [2:0] f3,
                                         input logic [31:0] addr);
    logic legal;
    if (ld && st) return 3'd4;
    if (ld) legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    else    legal = f3 inside {3'd0, 3'd1, 3'd2};
    if (!legal) return 3'd4;
    if ((addr % (32'd1 << f3[1:0])) != 0) return ld ? 3'd1 : 3'd2;
    return 3'd0;
  endfunction

  function automatic logic [3:0] m_be(input logic ld, input logic [2:0] f3, input logic [31:0] addr);
    if (ld) return 4'hf;
    if (f3 == 3'd0) return 4'(32'd1 << (addr % 4));
    if (f3 == 3'd1) return ((addr % 4) >= 2) ? 4'hc : 4'h3;
    return 4'hf;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    if (f3 == 3'd0) return (sd & 32'hff) * 32'h01010101;
    if (f3 == 3'd1) return (sd & 32'hffff) * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, rdata);
    logic [31:0] sh, v;
    sh = rdata >> (8 * (addr % 4));
    case (f3)
      3'd0: begin v = sh & 32'hff;   if (v >= 32'h80)   v = v + 32'hffffff00; end
      3'd4: v = sh & 32'hff;
      3'd1: begin v = sh & 32'hffff; if (v >= 32'h8000) v = v + 32'hffff0000; end
      3'd5: v = sh & 32'hffff;
      default: v = rdata;
    endcase
    return v;
  endfunction

  // driver: issue one access, act as the bus slave acking on request cycle ack_lat (0 = never)
  task automatic do_access(input logic ld, st, input logic [2:0] f3, input logic [31:0] addr, sd,
                           input logic [4:0] rd, input int ack_lat, input logic [31:0] rdata);
    int cyc;
    @(negedge Clk);
    En = 1'b1; IsLoad = ld; IsStore = st; Func3 = f3; Addr = addr; StoreData = sd; RdIn = rd;
    MemRData = rdata;
    @(negedge Clk);
    En = 1'b0; Addr = $urandom; StoreData = $urandom; RdIn = 5'($urandom); Func3 = 3'($urandom);
    obs_req_cycles = 0; obs_done_lat = 0; obs_stable = 1'b1; cyc = 1;
    while (cyc <= 20 && obs_done_lat == 0) begin
      if (Done) begin
        obs_done_lat = cyc; obs_load = LoadData; obs_wr = WriteReg; obs_rd = RdOut;
        obs_fault = Fault; obs_cause = FaultCause; obs_faddr = FaultAddr;
        obs_busy_done = Busy; obs_req_at_done = MemReq;
      end else if (MemReq) begin
        obs_req_cycles++;
        if (obs_req_cycles == 1) begin
          obs_addr = MemAddr; obs_we = MemWe; obs_wdata = MemWData; obs_be = MemBe;
        end else if (MemAddr !== obs_addr || MemWe !== obs_we || MemWData !== obs_wdata ||
                     MemBe !== obs_be) begin
          obs_stable = 1'b0;
        end
        MemAck = (obs_req_cycles == ack_lat);
      end
      if (obs_done_lat == 0) begin
        @(negedge Clk);
        MemAck = 1'b0;
        cyc++;
      end
    end
    @(negedge Clk);
    obs_done_after = Done; obs_busy_after = Busy;
  endtask

  task automatic test_reset_state;
    checks++;
    if ({Busy, Done, WriteReg, Fault, MemReq, MemWe} !== 6'd0 || LoadData !== 0 ||
        FaultCause !== 0 || FaultAddr !== 0 || MemAddr !== 0 || MemWData !== 0 ||
        MemBe !== 0 || RdOut !== 0 || DbgState !== 0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b req=%b be=%h addr=%h state=%0d, want all zero",
               Busy, Done, MemReq, MemBe, MemAddr, DbgState);
    end
  endtask

  task automatic test_store_word;
    do_access(1'b0, 1'b1, 3'd2, 32'h1000_0004, 32'hDEADBEEF, 5'd7, 3, 32'h0);
    checks++;
    if (obs_addr !== 32'h10000004 || obs_be !== 4'hf || obs_wdata !== 32'hDEADBEEF || obs_we !== 1'b1) begin
      errors++;
      $display("FAIL sw_bus addr=%h be=%h wdata=%h we=%b, want 10000004 f deadbeef 1",
               obs_addr, obs_be, obs_wdata, obs_we);
    end
    checks++;
    if (obs_done_lat !== 4 || obs_wr !== 1'b0 || obs_fault !== 1'b0 || obs_load !== 0) begin
      errors++;
      $display("FAIL sw_done lat=%0d wr=%b fault=%b load=%h, want 4 0 0 0",
               obs_done_lat, obs_wr, obs_fault, obs_load);
    end
    checks++;
    if (obs_stable !== 1'b1 || obs_done_after !== 1'b0 || obs_busy_after !== 1'b0) begin
      errors++;
      $display("FAIL sw_hold stable=%b done_after=%b busy_after=%b, want 1 0 0",
               obs_stable, obs_done_after, obs_busy_after);
    end
  endtask

  task automatic test_byte;
    do_access(1'b0, 1'b1, 3'd0, 32'h203, 32'h000000A5, 5'd0, 1, 32'h0);
    checks++;
    if (obs_be !== 4'b1000 || obs_wdata !== 32'hA5A5A5A5 || obs_done_lat !== 2) begin
      errors++;
      $display("FAIL sb be=%b wdata=%h lat=%0d, want 1000 a5a5a5a5 2", obs_be, obs_wdata, obs_done_lat);
    end
    do_access(1'b1, 1'b0, 3'd0, 32'h203, 32'h0, 5'd9, 2, 32'h80112233);
    checks++;
    if (obs_load !== 32'hFFFFFF80 || obs_wr !== 1'b1 || obs_rd !== 5'd9 || obs_be !== 4'hf || obs_we !== 1'b0) begin
      errors++;
      $display("FAIL lb load=%h wr=%b rd=%0d be=%h we=%b, want ffffff80 1 9 f 0",
               obs_load, obs_wr, obs_rd, obs_be, obs_we);
    end
    do_access(1'b1, 1'b0, 3'd4, 32'h203, 32'h0, 5'd9, 2, 32'h80112233);
    checks++;
    if (obs_load !== 32'h00000080) begin
      errors++;
      $display("FAIL lbu load=%h, want 00000080", obs_load);
    end
  endtask

  task automatic test_half;
    do_access(1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 5'd17, 1, 32'h8001_7FFF);
    checks++;
    if (obs_load !== 32'hFFFF8001 || obs_wr !== 1'b1 || obs_rd !== 5'd17 || obs_addr !== 32'h100) begin
      errors++;
      $display("FAIL lh load=%h wr=%b rd=%0d addr=%h, want ffff8001 1 17 100",
               obs_load, obs_wr, obs_rd, obs_addr);
    end
    do_access(1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 5'd17, 1, 32'h8001_7FFF);
    checks++;
    if (obs_load !== 32'h00008001) begin
      errors++;
      $display("FAIL lhu load=%h, want 00008001", obs_load);
    end
  endtask

  task automatic test_faults;
    do_access(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 5'd3, 1, 32'h0);
    checks++;
    if (obs_req_cycles !== 0 || obs_done_lat !== 1 || obs_fault !== 1'b1 || obs_cause !== 3'b001 ||
        obs_faddr !== 32'h101 || obs_wr !== 1'b0 || obs_busy_done !== 1'b1) begin
      errors++;
      $display("FAIL lw_misal req=%0d lat=%0d fault=%b cause=%b faddr=%h wr=%b busy=%b, want 0 1 1 001 101 0 1",
               obs_req_cycles, obs_done_lat, obs_fault, obs_cause, obs_faddr, obs_wr, obs_busy_done);
    end
    do_access(1'b0, 1'b1, 3'd1, 32'h3, 32'h0, 5'd3, 1, 32'h0);
    checks++;
    if (obs_req_cycles !== 0 || obs_cause !== 3'b010 || obs_faddr !== 32'h3) begin
      errors++;
      $display("FAIL sh_misal req=%0d cause=%b faddr=%h, want 0 010 3", obs_req_cycles, obs_cause, obs_faddr);
    end
    do_access(1'b1, 1'b0, 3'd3, 32'h40, 32'h0, 5'd3, 1, 32'h0);
    checks++;
    if (obs_req_cycles !== 0 || obs_cause !== 3'b100 || obs_fault !== 1'b1) begin
      errors++;
      $display("FAIL illegal_f3 req=%0d cause=%b fault=%b, want 0 100 1", obs_req_cycles, obs_cause, obs_fault);
    end
    do_access(1'b1, 1'b1, 3'd2, 32'h40, 32'h0, 5'd3, 1, 32'h0);
    checks++;
    if (obs_req_cycles !== 0 || obs_cause !== 3'b100 || obs_wr !== 1'b0) begin
      errors++;
      $display("FAIL both_types req=%0d cause=%b wr=%b, want 0 100 0", obs_req_cycles, obs_cause, obs_wr);
    end
  endtask

  task automatic test_timeout;
    do_access(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 5'd4, 0, 32'h12345678);
    checks++;
    if (obs_req_cycles !== T || obs_done_lat !== T + 1 || obs_fault !== 1'b1 ||
        obs_cause !== 3'b011 || obs_wr !== 1'b0 || obs_load !== 0 || obs_req_at_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout req=%0d lat=%0d fault=%b cause=%b wr=%b req_at_done=%b, want %0d %0d 1 011 0 0",
               obs_req_cycles, obs_done_lat, obs_fault, obs_cause, obs_wr, obs_req_at_done, T, T + 1);
    end
    do_access(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 5'd4, T, 32'h12345678);
    checks++;
    if (obs_done_lat !== T + 1 || obs_fault !== 1'b0 || obs_load !== 32'h12345678 || obs_wr !== 1'b1) begin
      errors++;
      $display("FAIL ack_at_limit lat=%0d fault=%b load=%h wr=%b, want %0d 0 12345678 1",
               obs_done_lat, obs_fault, obs_load, obs_wr, T + 1);
    end
  endtask

  task automatic test_noop;
    @(negedge Clk);
    En = 1'b1; IsLoad = 1'b0; IsStore = 1'b0; Func3 = 3'd2; Addr = 32'h80;
    @(negedge Clk);
    En = 1'b0;
    checks++;
    if (Busy !== 1'b0 || MemReq !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL noop busy=%b req=%b done=%b, want 0 0 0", Busy, MemReq, Done);
    end
  endtask

  task automatic test_async_reset;
    logic saw_done;
    @(negedge Clk);
    En = 1'b1; IsLoad = 1'b1; IsStore = 1'b0; Func3 = 3'd2; Addr = 32'h40;
    @(negedge Clk);
    En = 1'b0;
    @(negedge Clk);
    checks++;
    if (MemReq !== 1'b1 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre req=%b busy=%b, want 1 1", MemReq, Busy);
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if (MemReq !== 1'b0 || Busy !== 1'b0 || DbgState !== 2'd0) begin
      errors++;
      $display("FAIL reset_async req=%b busy=%b state=%0d, want 0 0 0", MemReq, Busy, DbgState);
    end
    @(negedge Clk);
    Reset_n = 1'b1; MemAck = 1'b1;
    @(negedge Clk);
    MemAck = 1'b0;
    saw_done = Done;
    repeat (3) begin
      @(negedge Clk);
      saw_done = saw_done | Done | Busy;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL late_ack done_or_busy=%b, want 0", saw_done);
    end
  endtask

  task automatic test_back_to_back;
    int reqc, dones, rises;
    logic prev_req, bad;
    reqc = 0; dones = 0; rises = 0; prev_req = 1'b0; bad = 1'b0;
    @(negedge Clk);
    En = 1'b1; IsLoad = 1'b1; IsStore = 1'b0; Func3 = 3'd2; Addr = 32'h80; MemRData = 32'h55;
    for (int c = 0; c < 16; c++) begin
      @(negedge Clk);
      if (MemReq && Done) bad = 1'b1;
      if (MemReq && !prev_req) begin
        rises++;
        if (dones != rises - 1) bad = 1'b1;
      end
      if (Done) dones++;
      if (MemReq) reqc++; else reqc = 0;
      MemAck = (reqc == 2);
      prev_req = MemReq;
    end
    En = 1'b0; MemAck = 1'b0;
    repeat (8) @(negedge Clk);
    checks++;
    if (bad !== 1'b0 || dones < 3 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back overlap=%b dones=%0d busy=%b, want 0 >=3 0", bad, dones, Busy);
    end
  endtask

  task automatic test_random;
    logic ld, st;
    logic [2:0] f3, ec;
    logic [31:0] addr, sd, rdata, el;
    logic [4:0] rd;
    int lat, elat, ereq;
    for (int n = 0; n < 60; n++) begin
      ld = ($urandom_range(0, 1) == 1);
      st = ($urandom_range(0, 9) == 0) ? 1'b1 : !ld;
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (ld ? 3'($urandom_range(0, 2)) | ($urandom_range(0,1) ? 3'd4 : 3'd0) & 3'd5 : 3'($urandom_range(0, 2)));
      addr = $urandom; sd = $urandom; rdata = $urandom; rd = 5'($urandom);
      if ($urandom_range(0, 2) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 1);
      lat = $urandom_range(1, T + 2);
      do_access(ld, st, f3, addr, sd, rd, lat, rdata);
      ec = m_cause(ld, st, f3, addr);
      if (ec != 0)       begin elat = 1;       ereq = 0; end
      else if (lat <= T) begin elat = lat + 1; ereq = lat; end
      else               begin elat = T + 1;   ereq = T; ec = 3'd3; end
      el = (ec == 0 && ld) ? m_load(f3, addr, rdata) : 32'd0;
      checks++;
      if (obs_done_lat !== elat || obs_req_cycles !== ereq || obs_cause !== ec || obs_fault !== (ec != 0) ||
          obs_wr !== (ec == 0 && ld) || obs_load !== el || obs_rd !== rd ||
          obs_done_after !== 1'b0 || obs_busy_after !== 1'b0) begin
        errors++;
        $display("FAIL rand_resp n=%0d ld=%b st=%b f3=%0d addr=%h lat=%0d/%0d req=%0d/%0d cause=%0d/%0d load=%h/%h wr=%b rd=%0d/%0d",
                 n, ld, st, f3, addr, obs_done_lat, elat, obs_req_cycles, ereq, obs_cause, ec,
                 obs_load, el, obs_wr, obs_rd, rd);
      end
      if (ereq != 0) begin
        checks++;
        if (obs_addr !== (addr & 32'hFFFFFFFC) || obs_we !== st || obs_be !== m_be(ld, f3, addr) ||
            (st && obs_wdata !== m_wdata(f3, sd)) || obs_stable !== 1'b1) begin
          errors++;
          $display("FAIL rand_bus n=%0d addr=%h we=%b be=%h/%h wdata=%h/%h stable=%b",
                   n, obs_addr, obs_we, obs_be, m_be(ld, f3, addr), obs_wdata, m_wdata(f3, sd), obs_stable);
        end
      end else if (ec != 3'd3) begin
        checks++;
        if (obs_faddr !== addr) begin
          errors++;
          $display("FAIL rand_faddr n=%0d faddr=%h, want %h", n, obs_faddr, addr);
        end
      end
    end
  endtask

  initial begin
    Reset_n = 1'b0; En = 1'b0; IsLoad = 1'b0; IsStore = 1'b0; Func3 = 3'd0; Addr = 32'd0;
    StoreData = 32'd0; RdIn = 5'd0; MemRData = 32'd0; MemAck = 1'b0;
    repeat (3) @(negedge Clk);
    test_reset_state;
    Reset_n = 1'b1;
    test_store_word;
    test_byte;
    test_half;
    test_faults;
    test_timeout;
    test_noop;
    test_async_reset;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the ALU. Takes the effective address (ALU DataResult), store data and funct3, and runs one single-beat transaction on the data-memory bus with a req/ack handshake.
- Performs byte-lane steering and byte-enable generation for stores, and lane extraction with sign/zero extension for loads.
- Detects misaligned addresses, illegal funct3 values and bus timeouts, and reports them as faults to the control unit.

Parameters:
- TIMEOUT_CYCLES, 255: number of cycles in REQ without MemAck before a bus-timeout fault; legal range 1..65535.

Ports:
- Clk  input  1  clock, rising edge
- Reset_n  input  1  asynchronous active-low reset
- En  input  1  start request, sampled in IDLE only
- IsLoad  input  1  access is a load
- IsStore  input  1  access is a store
- Func3  input  3  RV32I load/store funct3
- Addr  input  32  effective address from ALU DataResult
- StoreData  input  32  rs2 value
- RdIn  input  5  destination register of the load
- Busy  output  1  stage occupied (state != IDLE)
- Done  output  1  one-cycle completion pulse
- LoadData  output  32  extended load result, valid while Done=1
- WriteReg  output  1  register write-back enable, valid while Done=1
- RdOut  output  5  latched RdIn
- Fault  output  1  access faulted, valid while Done=1
- FaultCause  output  3  000 none, 001 load misaligned, 010 store misaligned, 011 bus timeout, 100 illegal
- FaultAddr  output  32  latched Addr, valid while Fault=1
- MemReq  output  1  bus request
- MemWe  output  1  1 = write
- MemAddr  output  32  word address, {Addr[31:2],2'b00}
- MemWData  output  32  lane-replicated store data
- MemBe  output  4  byte enables
- MemRData  input  32  read data, valid when MemAck=1
- MemAck  input  1  bus completion, one-cycle pulse

Behaviour:
- Reset: asynchronous; all outputs and registers go to 0, state IDLE, MemReq drops immediately. A transaction in flight is abandoned, and a later MemAck is ignored.
- States: IDLE, REQ, RESP.
- IDLE, En=1, exactly one of IsLoad/IsStore set:
  - Latch Addr, Func3, StoreData, RdIn and the access type.
  - Legal and aligned: go to REQ.
  - Illegal or misaligned: go to RESP with Fault=1; no bus activity.
- IDLE, En=1, neither type set: no operation; the unit stays in IDLE.
- IDLE, En=1, both types set: illegal, cause 100.
- Legal Func3: loads 000/001/010/100/101; stores 000/001/010. Anything else is cause 100.
- Alignment:
  - Halfword accesses need Addr[0]=0.
  - Word accesses need Addr[1:0]=00.
  - A violation gives cause 001 for a load, 010 for a store.
- REQ:
  - MemReq=1 and MemAddr/MemWe/MemWData/MemBe are registered and held stable until MemAck is sampled high.
  - On MemAck: capture extended load data, deassert MemReq next cycle, go to RESP.
  - The timeout counter starts at 0 on REQ entry and increments each cycle without ack. When it reaches TIMEOUT_CYCLES, drop MemReq, go to RESP with Fault=1, cause 011.
  - MemAck in the same cycle the counter hits the limit counts as success.
- RESP: Done=1 for exactly one cycle, then IDLE. WriteReg = IsLoad and not Fault. LoadData=0 on fault and on stores.
- Busy is registered, high in REQ and RESP. En while Busy=1 is ignored; the upstream stage holds its instruction until Done.
- Latency: En at cycle 0 → MemReq from cycle 1; MemAck at cycle k → Done at cycle k+1. Minimum is 2 cycles. A fault detected at accept → Done at cycle 1.
- MemAck outside REQ is ignored.
- Store lane steering:
  - SB: MemWData={4{StoreData[7:0]}}, MemBe=4'b0001<<Addr[1:0].
  - SH: MemWData={2{StoreData[15:0]}}, MemBe=Addr[1]?1100:0011.
  - SW: MemWData=StoreData, MemBe=1111.
- Loads: MemBe=1111, MemWe=0.
- Load extraction:
  - Byte = MemRData[8*Addr[1:0] +: 8].
  - Half = MemRData[16*Addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.

Test Plan:
- SW Addr=0x1000_0004, StoreData=0xDEADBEEF, ack 3 cycles after req → MemAddr=0x10000004, MemBe=1111, MemWData=0xDEADBEEF, MemWe=1; Done one cycle after ack; WriteReg=0, Fault=0.
- SB Addr=0x203, StoreData=0x000000A5 → MemBe=1000, MemWData=0xA5A5A5A5. Then LB at the same address with MemRData=0x80112233 → LoadData=0xFFFFFF80. LBU → 0x00000080.
- LH Addr=0x102, MemRData=0x8001_7FFF → LoadData=0xFFFF8001, WriteReg=1, RdOut=RdIn. LHU → 0x00008001.
- LW Addr=0x101 → no MemReq; Done at cycle 1 with Fault=1, FaultCause=001, FaultAddr=0x101. SH Addr=0x3 → cause 010. Load Func3=011 → cause 100.
- TIMEOUT_CYCLES=4, no ack → MemReq high for 4 cycles then low; Done with cause 011. A repeat with ack on the 4th cycle → success, Fault=0.
- Reset_n low mid-REQ → MemReq and Busy go to 0 asynchronously. A late MemAck after reset → no Done. A back-to-back En held high → second access accepted only after Done, MemReq never overlaps.
